// File: rtl/dmem_port_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | dmem_port_arbiter_if : core / ext / datamemory bus bundle for the arbiter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  core_req;
    logic                  core_we;
    logic [DM_ADDRESS-1:0] core_addr;
    logic [DATA_W-1:0]     core_wdata;
    logic [2:0]            core_funct3;
    logic                  core_gnt;
    logic                  core_stall;
    logic [DATA_W-1:0]     core_rdata;

    logic                  ext_req;
    logic                  ext_we;
    logic                  ext_lock;
    logic [DM_ADDRESS-1:0] ext_addr;
    logic [DATA_W-1:0]     ext_wdata;
    logic [2:0]            ext_funct3;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic [DATA_W-1:0]     ext_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_funct3,
        output core_gnt, core_stall, core_rdata,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata, ext_funct3,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_funct3,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_funct3,
        input  core_gnt, core_stall, core_rdata,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata, ext_funct3,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_funct3,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | dmem_port_arbiter : core-priority datamemory arbiter, ext starvation/burst|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    dmem_port_arbiter_if.slave      bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [BW-1:0] c_BURST_MAX  = BW'(BURST_MAX);

    typedef enum logic [0:0] {
        CORE_PRI  = 1'b0,
        EXT_BURST = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [SW-1:0]  r_starve_cnt, w_starve_nxt;
    logic [BW-1:0]  r_burst_cnt, w_burst_nxt;
    logic           r_block_ext, w_block_nxt;
    logic           r_ext_rvalid;
    logic [DATA_W-1:0] r_ext_rdata;

    logic           w_ext_gnt;
    logic           w_core_gnt;
    logic           w_starved;
    logic [BW-1:0]  w_burst_inc;

    // block_ext only matters against a competing core request
    always_comb begin
        w_starved   = (r_starve_cnt == c_STARVE_MAX);
        w_ext_gnt   = bus.ext_req &
                      (~bus.core_req | ((w_starved | (r_state == EXT_BURST)) & ~r_block_ext));
        w_core_gnt  = bus.core_req & ~w_ext_gnt;
        w_burst_inc = r_burst_cnt + 1'b1;
    end

    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = '0;
        if (w_ext_gnt) begin
            bus.mem_read   = ~bus.ext_we;
            bus.mem_write  = bus.ext_we;
            bus.mem_addr   = bus.ext_addr;
            bus.mem_wdata  = bus.ext_wdata;
            bus.mem_funct3 = bus.ext_funct3;
        end else if (w_core_gnt) begin
            bus.mem_read   = ~bus.core_we;
            bus.mem_write  = bus.core_we;
            bus.mem_addr   = bus.core_addr;
            bus.mem_wdata  = bus.core_wdata;
            bus.mem_funct3 = bus.core_funct3;
        end
    end

    assign bus.core_gnt   = w_core_gnt;
    assign bus.core_stall = bus.core_req & ~w_core_gnt;
    assign bus.core_rdata = bus.mem_rdata;
    assign bus.ext_gnt    = w_ext_gnt;
    assign bus.ext_rvalid = r_ext_rvalid;
    assign bus.ext_rdata  = r_ext_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_burst_nxt  = r_burst_cnt;
        w_block_nxt  = 1'b0;
        w_starve_nxt = '0;
        if (bus.ext_req & ~w_ext_gnt)
            w_starve_nxt = w_starved ? r_starve_cnt : r_starve_cnt + 1'b1;
        case (r_state)
            CORE_PRI: begin
                if (w_ext_gnt & bus.ext_lock) begin
                    w_state_nxt = EXT_BURST;
                    w_burst_nxt = BW'(1);
                end
            end
            EXT_BURST: begin
                if (~bus.ext_req | ~bus.ext_lock) begin
                    w_state_nxt = CORE_PRI;
                    w_burst_nxt = '0;
                end else if (w_ext_gnt) begin
                    // burst_cnt counts grants taken, so the cap is hit on the post-increment value
                    if (w_burst_inc >= c_BURST_MAX) begin
                        w_state_nxt = CORE_PRI;
                        w_burst_nxt = '0;
                        w_block_nxt = 1'b1;
                    end else begin
                        w_burst_nxt = w_burst_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = CORE_PRI;
                w_burst_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= CORE_PRI;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
            r_block_ext  <= 1'b0;
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_burst_cnt  <= w_burst_nxt;
            r_block_ext  <= w_block_nxt;
            r_ext_rvalid <= w_ext_gnt & ~bus.ext_we;
            if (w_ext_gnt & ~bus.ext_we)
                r_ext_rdata <= bus.mem_rdata;
        end
    end

endmodule

`default_nettype wire
